// File: rtl/spi_target_regif.sv
// SPI target that oversamples SCK/SS/MOSI and bridges each
// command/address/data frame onto a register req/ack bus.
module spi_target_regif #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clock_polarity,
  input  logic                     clock_phase,
  input  logic                     SCK,
  input  logic                     SS,
  input  logic                     MOSI,
  output logic                     MISO,
  output logic [ADDRESS_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0]    reg_wdata,
  output logic                     reg_we,
  output logic                     reg_re,
  input  logic [DATA_WIDTH-1:0]    reg_rdata,
  input  logic                     reg_ack,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     frame_error
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int MW = (AW > DW) ? AW : DW;
  localparam int CW = $clog2(MW + 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    WRITE_REQ,
    DONE,
    WAIT_SS
  } state_t;

  state_t        state;
  logic [1:0]    sck_sy;
  logic [1:0]    ss_sy;
  logic [1:0]    mosi_sy;
  logic          sck_d;
  logic          ss_d;
  logic [CW-1:0] cnt;
  logic          rd_we;
  logic [AW-1:0] addr_sh;
  logic [DW-1:0] rx_sh;
  logic [DW-1:0] tx_sh;
  logic          late;
  logic          loaded;
  logic          launched;

  logic sck_s;
  logic ss_s;
  logic mosi_b;
  logic lead;
  logic trail;
  logic sample_ev;
  logic launch_ev;
  logic ss_fall;
  logic ss_rise;
  logic ack_ok;

  assign sck_s  = sck_sy[1];
  assign ss_s   = ss_sy[1];
  assign mosi_b = mosi_sy[1];

  assign lead  = (sck_s != clock_polarity) &&
                 (sck_d == clock_polarity);
  assign trail = (sck_s == clock_polarity) &&
                 (sck_d != clock_polarity);

  assign sample_ev = clock_phase ? trail : lead;
  assign launch_ev = clock_phase ? lead : trail;

  assign ss_fall = !ss_s && ss_d;
  assign ss_rise = ss_s && !ss_d;
  assign ack_ok  = reg_re && reg_ack;

  // SS held low across a reset must not look like a fresh frame
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_sy  <= '0;
      ss_sy   <= '0;
      mosi_sy <= '0;
      sck_d   <= 1'b0;
      ss_d    <= 1'b0;
    end else begin
      sck_sy  <= {sck_sy[0], SCK};
      ss_sy   <= {ss_sy[0], SS};
      mosi_sy <= {mosi_sy[0], MOSI};
      sck_d   <= sck_s;
      ss_d    <= ss_s;
    end
  end

  assign MISO = !SS && (state == DATA) && tx_sh[DW-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_we       <= 1'b0;
      addr_sh     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      late        <= 1'b0;
      loaded      <= 1'b0;
      launched    <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;

      // read acks are consumed in any state; data only kept if on time
      if (ack_ok) begin
        reg_re <= 1'b0;
        if (state == DATA && !launched && !rd_we) begin
          tx_sh  <= reg_rdata;
          loaded <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (ss_fall) begin
            state    <= CMD;
            busy     <= 1'b1;
            cnt      <= '0;
            tx_sh    <= '0;
            late     <= 1'b0;
            loaded   <= 1'b0;
            launched <= 1'b0;
          end
        end
        CMD: begin
          if (sample_ev) begin
            rd_we <= mosi_b;
            cnt   <= '0;
            state <= ADDR;
          end else if (ss_rise) begin
            frame_error <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        ADDR: begin
          if (sample_ev) begin
            addr_sh <= {addr_sh[AW-2:0], mosi_b};
            cnt     <= cnt + 1'b1;
            if (cnt == CW'(AW - 1)) begin
              reg_addr <= {addr_sh[AW-2:0], mosi_b};
              cnt      <= '0;
              state    <= DATA;
              if (!rd_we) reg_re <= 1'b1;
            end
          end else if (ss_rise) begin
            frame_error <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        DATA: begin
          if (sample_ev) begin
            rx_sh <= {rx_sh[DW-2:0], mosi_b};
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(DW - 1)) begin
              if (rd_we) begin
                reg_wdata <= {rx_sh[DW-2:0], mosi_b};
                reg_we    <= 1'b1;
                state     <= WRITE_REQ;
              end else begin
                state <= DONE;
              end
            end
          end else if (ss_rise) begin
            frame_error <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
          // first launch only checks the data arrived; MSB is already out
          if (launch_ev) begin
            launched <= 1'b1;
            if (launched) begin
              tx_sh <= {tx_sh[DW-2:0], 1'b0};
            end else if (!rd_we && !loaded && !ack_ok) begin
              frame_error <= 1'b1;
              late        <= 1'b1;
              tx_sh       <= '0;
            end
          end
        end
        WRITE_REQ: begin
          if (reg_ack) begin
            reg_we <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          frame_done <= !late;
          state      <= WAIT_SS;
        end
        WAIT_SS: begin
          if (ss_s) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target_regif.sv
// Randomised bench: SPI master model, bus memory responder and a
// frame-level reference model for spi_target_regif.
module tb_spi_target_regif;

  localparam int H = 8;
  localparam int N = 65;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        sck = 1'b0;
  logic        ss = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata = '0;
  logic        reg_ack = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        frame_error;

  spi_target_regif #(
    .DATA_WIDTH(32),
    .ADDRESS_WIDTH(32)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .clock_polarity(cpol),
    .clock_phase(cpha),
    .SCK(sck),
    .SS(ss),
    .MOSI(mosi),
    .MISO(miso),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we(reg_we),
    .reg_re(reg_re),
    .reg_rdata(reg_rdata),
    .reg_ack(reg_ack),
    .busy(busy),
    .frame_done(frame_done),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int done_cnt = 0;
  int err_cnt = 0;

  always @(negedge clock) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_error === 1'b1) err_cnt++;
  end

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hC3A5_0F96;
  endfunction

  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          ack_delay = 2;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic        rq_w;
  logic [31:0] rq_a;
  logic [31:0] rq_d;

  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && (reg_we || reg_re)) begin
        rq_w = reg_we;
        rq_a = reg_addr;
        rq_d = reg_wdata;
        repeat (ack_delay - 1) @(negedge clock);
        if (rq_w) begin
          bus_mem[rq_a] = rq_d;
          wr_cnt++;
          last_waddr = rq_a;
          last_wdata = rq_d;
        end else begin
          reg_rdata = bus_mem.exists(rq_a) ? bus_mem[rq_a]
                                           : dflt(rq_a);
          rd_cnt++;
        end
        reg_ack = 1'b1;
        @(negedge clock);
        reg_ack = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  task automatic spi_frame(input logic pol, input logic pha,
                           input logic [N-1:0] bits,
                           input int stop_at, input bit do_rst,
                           output logic [N-1:0] rx);
    cpol = pol;
    cpha = pha;
    @(negedge clock);
    sck = pol;
    repeat (4) @(negedge clock);
    ss = 1'b0;
    rx = '0;
    for (int i = 0; i < N; i++) begin
      if (i == stop_at) begin
        if (do_rst) begin
          reset_n = 1'b0;
          @(negedge clock);
          check("rst_data", {reg_addr, reg_wdata}, 64'd0);
          check("rst_ctl", {58'd0, miso, reg_we, reg_re, busy,
                            frame_done, frame_error}, 64'd0);
          @(negedge clock);
          reset_n = 1'b1;
        end
        break;
      end
      if (!pha) mosi = bits[N-1-i];
      repeat (H) @(negedge clock);
      sck = ~pol;
      if (!pha) rx[N-1-i] = miso;
      else mosi = bits[N-1-i];
      repeat (H) @(negedge clock);
      sck = pol;
      if (pha) rx[N-1-i] = miso;
    end
    repeat (H) @(negedge clock);
    ss = 1'b1;
    sck = pol;
    repeat (12) @(negedge clock);
  endtask

  task automatic do_write(input logic pol, input logic pha,
                          input logic [31:0] a, input logic [31:0] d,
                          input int dly);
    int w0, r0, d0, e0;
    logic [N-1:0] rx;
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt;
    ack_delay = dly;
    spi_frame(pol, pha, {1'b1, a, d}, -1, 1'b0, rx);
    ref_mem[a] = d;
    check("wr_count", 64'(wr_cnt - w0), 64'd1);
    check("wr_no_read", 64'(rd_cnt - r0), 64'd0);
    check("wr_addr", {32'd0, last_waddr}, {32'd0, a});
    check("wr_data", {32'd0, last_wdata}, {32'd0, d});
    check("wr_done", 64'(done_cnt - d0), 64'd1);
    check("wr_error", 64'(err_cnt - e0), 64'd0);
    check("wr_busy", {63'd0, busy}, 64'd0);
    check("wr_miso_hdr", 64'(rx[N-1:32]), 64'd0);
  endtask

  task automatic do_read(input logic pol, input logic pha,
                         input logic [31:0] a, input int dly);
    int r0, d0, e0;
    bit late;
    logic [31:0] exp;
    logic [N-1:0] rx;
    r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt;
    late = (dly > H);
    exp = late ? 32'd0 : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
    ack_delay = dly;
    spi_frame(pol, pha, {1'b0, a, 32'd0}, -1, 1'b0, rx);
    check("rd_count", 64'(rd_cnt - r0), 64'd1);
    check("rd_data", {32'd0, rx[31:0]}, {32'd0, exp});
    check("rd_miso_hdr", 64'(rx[N-1:32]), 64'd0);
    check("rd_done", 64'(done_cnt - d0), late ? 64'd0 : 64'd1);
    check("rd_error", 64'(err_cnt - e0), late ? 64'd1 : 64'd0);
    check("rd_idle", {62'd0, busy, reg_re}, 64'd0);
  endtask

  initial begin
    logic [N-1:0] rx;
    int w0, d0, e0;
    logic [31:0] a, d;
    int m;

    repeat (3) @(negedge clock);
    check("reset_data", {reg_addr, reg_wdata}, 64'd0);
    check("reset_ctl", {58'd0, miso, reg_we, reg_re, busy,
                        frame_done, frame_error}, 64'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    do_write(1'b0, 1'b0, 32'h10, 32'hA5A5A5A5, 2);

    bus_mem[32'h10] = 32'h5A5A5A5A;
    ref_mem[32'h10] = 32'h5A5A5A5A;
    do_read(1'b0, 1'b0, 32'h10, 3);

    do_write(1'b1, 1'b1, 32'h0000ABCD, 32'h12345678, 2);
    do_read(1'b1, 1'b1, 32'h0000ABCD, 2);

    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    spi_frame(1'b0, 1'b0, {1'b1, 32'h4, 32'h11111111}, 20, 1'b0, rx);
    check("abort_error", 64'(err_cnt - e0), 64'd1);
    check("abort_no_we", 64'(wr_cnt - w0), 64'd0);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_idle", {62'd0, busy, reg_we}, 64'd0);
    do_write(1'b0, 1'b0, 32'h4, 32'hDEADBEEF, 1);

    do_read(1'b0, 1'b0, 32'h10, 40);

    w0 = wr_cnt;
    spi_frame(1'b0, 1'b0, {1'b1, 32'h10, 32'hA5A5A5A5}, 12, 1'b1, rx);
    check("rst_no_we", 64'(wr_cnt - w0), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    do_write(1'b0, 1'b0, 32'h10, 32'hA5A5A5A5, 2);

    for (int k = 0; k < 12; k++) begin
      m = $urandom_range(0, 3);
      a = 32'($urandom_range(0, 7)) << 2;
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        do_write(m[1], m[0], a, d, $urandom_range(1, 4));
      end else if ($urandom_range(0, 4) == 0) begin
        do_read(m[1], m[0], a, 40);
      end else begin
        do_read(m[1], m[0], a, $urandom_range(1, 4));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
